// File: rtl/sha_round_core.sv
// sha_round_core: SHA-256 compression engine, one round per clock over 64 rounds
// Ports: clk, rst (async, active-high), start (begin in IDLE), h_in[255:0] (H0 in [255:224]),
//   w (W_t for index round), w_valid (stall qualifier), round[5:0] (schedule read index),
//   busy (ROUND/DONE), done (one-cycle final pulse), a..h (working variables).
// Build option SHA_ROUND_WVALID_EN: a round advances only while w_valid is high.
module sha_round_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w,
  input  logic         w_valid,
  output logic [5:0]   round,
  output logic         busy,
  output logic         done,
  output logic [31:0]  a,
  output logic [31:0]  b,
  output logic [31:0]  c,
  output logic [31:0]  d,
  output logic [31:0]  e,
  output logic [31:0]  f,
  output logic [31:0]  g,
  output logic [31:0]  h
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  state_t state, state_nx;
  logic adv;
  logic [31:0] t1, t2;
`ifdef SHA_ROUND_WVALID_EN
  assign adv = w_valid;
`else
  logic unused_w_valid;
  assign unused_w_valid = w_valid;
  assign adv = 1'b1;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    t1 = h + ({e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]}) + ((e & f) ^ (~e & g)) + K[round] + w;
    t2 = ({a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]}) + ((a & b) ^ (a & c) ^ (b & c));
  end
  always_comb begin
    state_nx = state == IDLE  ? (start ? ROUND : IDLE) :
               state == ROUND ? (adv && round == 6'd63 ? DONE : ROUND) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        {a, b, c, d, e, f, g, h} <= h_in;
        round <= '0;
      end else if (state == ROUND && adv) begin
        {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
        round <= round == 6'd63 ? round : round + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_sha_round_core.sv
// tb_sha_round_core: scoreboard bench for sha_round_core against a SHA-256 reference model
module tb_sha_round_core;
  typedef struct {logic [255:0] v; int cyc;} exp_t;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_FINAL = 256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;
  localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
    32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'd0, 32'h000001c0};
  localparam logic [255:0] B_HASH = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic clk = 1'b0;
  logic rst, start, w_valid, busy, done;
  logic [255:0] h_in;
  logic [31:0] w, a, b, c, d, e, f, g, h;
  logic [5:0] round;
  logic [31:0] sched [64];
  exp_t exp_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  sha_round_core dut (.clk(clk), .rst(rst), .start(start), .h_in(h_in), .w(w), .w_valid(w_valid), .round(round),
    .busy(busy), .done(done), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign w = sched[round];
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] add256(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction
  function automatic logic [255:0] model(input logic [255:0] hv);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + sched[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction
  task automatic set_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      sched[i] = (rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10)) + sched[i-7] +
                 (rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3)) + sched[i-16];
  endtask
  task automatic launch(input logic [255:0] hv, input logic [511:0] blk, input int lat);
    set_block(blk);
    exp_q.delete();
    exp_q.push_back('{v: model(hv), cyc: cyc + lat});
    h_in = hv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; w_valid = 1'b1; h_in = '0;
    set_block(ABC);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (round !== 6'd0) begin n_fail++; $display("FAIL reset_round: got %0d want 0", round); end
    n_checks++; if ({a, b, c, d, e, f, g, h} !== 256'd0) begin n_fail++; $display("FAIL reset_vars: got %h want 0", {a, b, c, d, e, f, g, h}); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_abc;
    exp_t x;
    launch(IV, ABC, 65);
    @(negedge clk);
    n_checks++; if (a !== 32'h5d6aebcd) begin n_fail++; $display("FAIL abc_round0_a: got %h want 5d6aebcd", a); end
    n_checks++; if (e !== 32'hfa2a4622) begin n_fail++; $display("FAIL abc_round0_e: got %h want fa2a4622", e); end
    n_checks++; if (round !== 6'd1) begin n_fail++; $display("FAIL abc_round_idx: got %0d want 1", round); end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abc_timeout: got done=%b want 1", done); end
    if (done && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++; if ({a, b, c, d, e, f, g, h} !== x.v) begin n_fail++; $display("FAIL abc_model: got %h want %h", {a, b, c, d, e, f, g, h}, x.v); end
      n_checks++; if (cyc !== x.cyc) begin n_fail++; $display("FAIL abc_latency: got cycle %0d want %0d", cyc, x.cyc); end
      n_checks++; if ({a, b, c, d, e, f, g, h} !== ABC_FINAL) begin n_fail++; $display("FAIL abc_known: got %h want %h", {a, b, c, d, e, f, g, h}, ABC_FINAL); end
      n_checks++; if (g + 32'h1f83d9ab !== 32'hb410ff61) begin n_fail++; $display("FAIL abc_h6: got %h want b410ff61", g + 32'h1f83d9ab); end
      n_checks++; if (round !== 6'd63) begin n_fail++; $display("FAIL abc_round_end: got %0d want 63", round); end
    end
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL abc_idle_flags: got %b want 00", {busy, done}); end
    n_checks++; if ({a, b, c, d, e, f, g, h} !== ABC_FINAL) begin n_fail++; $display("FAIL abc_idle_hold: got %h want %h", {a, b, c, d, e, f, g, h}, ABC_FINAL); end
  endtask
  task automatic test_latency;
    exp_t x;
    launch(IV, ABC, 65);
    for (int i = 1; i <= 66; i++) begin
      n_checks++; if (busy !== (i <= 65)) begin n_fail++; $display("FAIL lat_busy_%0d: got %b want %b", i, busy, i <= 65); end
      n_checks++; if (done !== (i == 65)) begin n_fail++; $display("FAIL lat_done_%0d: got %b want %b", i, done, i == 65); end
      if (done && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_checks++; if ({a, b, c, d, e, f, g, h} !== x.v) begin n_fail++; $display("FAIL lat_model: got %h want %h", {a, b, c, d, e, f, g, h}, x.v); end
      end
      @(negedge clk);
    end
  endtask
  task automatic test_start_busy;
    exp_t x;
    launch(IV, ABC, 65);
    for (int i = 0; i < 100 && round != 6'd20; i++) @(negedge clk);
    n_checks++; if (round !== 6'd20) begin n_fail++; $display("FAIL busy_reach20: got %0d want 20", round); end
    h_in = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_timeout: got done=%b want 1", done); end
    if (done && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++; if ({a, b, c, d, e, f, g, h} !== x.v) begin n_fail++; $display("FAIL busy_model: got %h want %h", {a, b, c, d, e, f, g, h}, x.v); end
      n_checks++; if (cyc !== x.cyc) begin n_fail++; $display("FAIL busy_latency: got cycle %0d want %0d", cyc, x.cyc); end
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid;
    exp_t x;
    launch(IV, ABC, 65);
    for (int i = 0; i < 100 && round != 6'd30; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (round !== 6'd0) begin n_fail++; $display("FAIL mid_round: got %0d want 0", round); end
    n_checks++; if ({a, b, c, d, e, f, g, h} !== 256'd0) begin n_fail++; $display("FAIL mid_vars: got %h want 0", {a, b, c, d, e, f, g, h}); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(IV, ABC, 65);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_timeout: got done=%b want 1", done); end
    if (done && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++; if ({a, b, c, d, e, f, g, h} !== x.v) begin n_fail++; $display("FAIL mid_model: got %h want %h", {a, b, c, d, e, f, g, h}, x.v); end
      n_checks++; if (cyc !== x.cyc) begin n_fail++; $display("FAIL mid_latency: got cycle %0d want %0d", cyc, x.cyc); end
    end
    repeat (2) @(negedge clk);
  endtask
`ifdef SHA_ROUND_WVALID_EN
  task automatic test_stall;
    exp_t x;
    int s5, s63;
    s5 = 0; s63 = 0;
    launch(IV, ABC, 69);
    for (int i = 0; i < 120 && !done; i++) begin
      w_valid = 1'b1;
      if (round == 6'd5 && s5 < 3) begin w_valid = 1'b0; s5++; end
      else if (round == 6'd63 && s63 < 1) begin w_valid = 1'b0; s63++; end
      @(negedge clk);
    end
    w_valid = 1'b1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: got done=%b want 1", done); end
    if (done && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++; if ({a, b, c, d, e, f, g, h} !== ABC_FINAL) begin n_fail++; $display("FAIL stall_known: got %h want %h", {a, b, c, d, e, f, g, h}, ABC_FINAL); end
      n_checks++; if (cyc !== x.cyc) begin n_fail++; $display("FAIL stall_latency: got cycle %0d want %0d", cyc, x.cyc); end
    end
    repeat (2) @(negedge clk);
  endtask
`endif
  task automatic test_back_to_back;
    exp_t x;
    int d1;
    logic [255:0] hmid;
    d1 = 0;
    hmid = IV;
    launch(IV, B1, 65);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_timeout: got done=%b want 1", done); end
    if (done && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++; if ({a, b, c, d, e, f, g, h} !== x.v) begin n_fail++; $display("FAIL b2b_first_model: got %h want %h", {a, b, c, d, e, f, g, h}, x.v); end
      hmid = add256(IV, x.v);
    end
    d1 = cyc;
    @(negedge clk);
    launch(hmid, B2, 65);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_timeout: got done=%b want 1", done); end
    if (done && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++; if ({a, b, c, d, e, f, g, h} !== x.v) begin n_fail++; $display("FAIL b2b_second_model: got %h want %h", {a, b, c, d, e, f, g, h}, x.v); end
      n_checks++; if (cyc - d1 !== 66) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 66", cyc - d1); end
      n_checks++; if (add256(hmid, {a, b, c, d, e, f, g, h}) !== B_HASH) begin n_fail++; $display("FAIL b2b_digest: got %h want %h", add256(hmid, {a, b, c, d, e, f, g, h}), B_HASH); end
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_abc();
    test_latency();
    test_start_busy();
    test_reset_mid();
`ifdef SHA_ROUND_WVALID_EN
    test_stall();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
